// File: rtl/memory_pkg.sv
// memory_pkg: FSM state encoding and even-parity helper shared by the memory responder and bus checkers.
package memory_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRIVE = 2'd2,
    ACK   = 2'd3
  } state_t;

  // Widest word the parity helper accepts; narrower words are zero-extended, which leaves parity unchanged.
  localparam int PARITY_MAX_W = 64;

  // Even-parity bit: makes the total number of ones (data plus this bit) even.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/memory_cell_array.sv
// memory_cell_array: 2^M x W register file with async clear, synchronous write and combinational read.
module memory_cell_array
  import memory_pkg::*;
#(
  parameter int W = 8,
  parameter int M = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [M-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic [M-1:0] raddr,
  output logic [W-1:0] rdata
);

  logic [W-1:0] mem [2**M];

  // Every cell clears on reset; one cell is written per accepted write request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**M; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/memory_unit.sv
// memory_unit: bus responder for the executor's memory; optional read parity checking with MEMORY_PARITY_EN.
module memory_unit
  import memory_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 2
) (
  input  logic         Clock,
  input  logic         ResetN,
  input  logic         MemoryEnable,
  input  logic [M-1:0] MemorySelect,
  input  logic         MemoryRW,
  inout  wire  [N-1:0] MemoryData,
  output logic         MemoryReady
`ifdef MEMORY_PARITY_EN
  ,
  output logic         ParityError
`endif
);

`ifdef MEMORY_PARITY_EN
  localparam int W = N + 1;
`else
  localparam int W = N;
`endif

  state_t       state;
  logic [M-1:0] addr;
  logic [N-1:0] dout;
  logic         drive;
  logic         we;
  logic [W-1:0] wdata;
  logic [W-1:0] rdata;

  // Writes land in the array on the same edge that accepts them.
  assign we = (state == IDLE) && MemoryEnable && MemoryRW;

`ifdef MEMORY_PARITY_EN
  logic perr;
  assign wdata       = {even_parity(PARITY_MAX_W'(MemoryData)), MemoryData};
  assign ParityError = perr;
`else
  assign wdata = MemoryData;
`endif

  memory_cell_array #(.W(W), .M(M)) u_cells (
    .clk   (Clock),
    .rst_n (ResetN),
    .we    (we),
    .waddr (MemorySelect),
    .wdata (wdata),
    .raddr (addr),
    .rdata (rdata)
  );

  // Bus is released asynchronously because drive clears the moment reset asserts.
  assign MemoryData = drive ? dout : {N{1'bz}};

  // Request sequencer: accept in IDLE, read through READ/DRIVE, acknowledge writes in ACK.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state       <= IDLE;
      addr        <= '0;
      dout        <= '0;
      drive       <= 1'b0;
      MemoryReady <= 1'b0;
`ifdef MEMORY_PARITY_EN
      perr        <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (MemoryEnable) begin
            addr        <= MemorySelect;
            state       <= MemoryRW ? ACK : READ;
            MemoryReady <= MemoryRW;
          end
        end
        READ: begin
          dout        <= rdata[N-1:0];
          drive       <= 1'b1;
          MemoryReady <= 1'b1;
          state       <= DRIVE;
`ifdef MEMORY_PARITY_EN
          perr        <= rdata[N] != even_parity(PARITY_MAX_W'(rdata[N-1:0]));
`endif
        end
        DRIVE: begin
          drive       <= 1'b0;
          MemoryReady <= 1'b0;
          state       <= IDLE;
`ifdef MEMORY_PARITY_EN
          perr        <= 1'b0;
`endif
        end
        ACK: begin
          MemoryReady <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_unit.sv
// tb_memory_unit: table-driven and scoreboarded checks of memory_unit latency, bus release, reset and parity.
module tb_memory_unit;

  localparam int N = 8;
  localparam int M = 2;
  localparam logic [N-1:0] HIZ = 8'hFF;

  typedef struct {
    logic         rw;
    logic [M-1:0] addr;
    logic [N-1:0] data;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         en = 1'b0;
  logic         rw = 1'b0;
  logic [M-1:0] sel = '0;
  logic [N-1:0] tb_data = '0;
  logic         tb_oe = 1'b0;
  logic         ready;
  wire  [N-1:0] bus;
`ifdef MEMORY_PARITY_EN
  logic         perr;
`endif

  int checks = 0;
  int errors = 0;
  logic [N-1:0] sb[$];
  vec_t tbl[8];
  logic [N-1:0] bb_vals[4];

  assign bus = tb_oe ? tb_data : {N{1'bz}};
  for (genvar g = 0; g < N; g++) begin : g_pu
    pullup (bus[g]);
  end

  always #5 clk = ~clk;

  memory_unit #(.N(N), .M(M)) dut (
    .Clock        (clk),
    .ResetN       (rst_n),
    .MemoryEnable (en),
    .MemorySelect (sel),
    .MemoryRW     (rw),
    .MemoryData   (bus),
    .MemoryReady  (ready)
`ifdef MEMORY_PARITY_EN
    ,
    .ParityError  (perr)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_chk(input string name);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got data %0h with empty scoreboard", name, bus);
    end else begin
      chk(name, bus, sb.pop_front());
    end
  endtask

  task automatic do_write(input logic [M-1:0] a, input logic [N-1:0] d);
    @(negedge clk);
    en = 1'b1; rw = 1'b1; sel = a; tb_data = d; tb_oe = 1'b1;
    @(negedge clk);
    en = 1'b0; tb_oe = 1'b0;
    #1;
    chk("wr_ready", ready, 1);
    chk("wr_hiz", bus, HIZ);
    @(negedge clk);
    #1;
    chk("wr_ready_end", ready, 0);
  endtask

  task automatic do_read(input logic [M-1:0] a, input logic [N-1:0] exp, input logic exp_pe);
    sb.push_back(exp);
    @(negedge clk);
    en = 1'b1; rw = 1'b0; sel = a; tb_oe = 1'b0;
    @(negedge clk);
    en = 1'b0;
    #1;
    chk("rd_wait_ready", ready, 0);
    chk("rd_wait_hiz", bus, HIZ);
    @(negedge clk);
    #1;
    chk("rd_ready", ready, 1);
    pop_chk("rd_data");
`ifdef MEMORY_PARITY_EN
    chk("rd_parity", perr, exp_pe);
`else
    if (exp_pe) $display("note: parity expectation ignored without MEMORY_PARITY_EN");
`endif
    @(negedge clk);
    #1;
    chk("rd_done_ready", ready, 0);
    chk("rd_done_hiz", bus, HIZ);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 2'd2, 8'hA5};
    tbl[1] = '{1'b0, 2'd2, 8'hA5};
    tbl[2] = '{1'b1, 2'd0, 8'h5A};
    tbl[3] = '{1'b1, 2'd3, 8'hC3};
    tbl[4] = '{1'b0, 2'd0, 8'h5A};
    tbl[5] = '{1'b0, 2'd3, 8'hC3};
    tbl[6] = '{1'b0, 2'd1, 8'h00};
    tbl[7] = '{1'b0, 2'd2, 8'hA5};
    bb_vals = '{8'h11, 8'h22, 8'h33, 8'h44};

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ready", ready, 0);
    chk("reset_hiz", bus, HIZ);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].rw) do_write(tbl[i].addr, tbl[i].data);
      else do_read(tbl[i].addr, tbl[i].data, 1'b0);
    end

    for (int i = 0; i < 4; i++) do_write(i[M-1:0], 8'h60 + 8'(i));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_hiz", bus, HIZ);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) do_read(i[M-1:0], 8'h00, 1'b0);

    @(negedge clk);
    en = 1'b1; rw = 1'b1; tb_oe = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = i[M-1:0]; tb_data = bb_vals[i];
      @(negedge clk);
      #1;
      chk("bb_wr_ready", ready, 1);
      @(negedge clk);
      #1;
      chk("bb_wr_idle", ready, 0);
    end
    en = 1'b0; tb_oe = 1'b0;

    @(negedge clk);
    en = 1'b1; rw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel = i[M-1:0];
      sb.push_back(bb_vals[i]);
      @(negedge clk);
      #1;
      chk("bb_rd_busy", ready, 0);
      @(negedge clk);
      #1;
      chk("bb_rd_ready", ready, 1);
      pop_chk("bb_rd_data");
      @(negedge clk);
      #1;
      chk("bb_rd_idle", ready, 0);
      chk("bb_rd_hiz", bus, HIZ);
    end
    en = 1'b0;

    sb.push_back(8'h33);
    @(negedge clk);
    en = 1'b1; rw = 1'b0; sel = 2'd2;
    @(negedge clk);
    rw = 1'b1; sel = 2'd1; tb_data = 8'h99; tb_oe = 1'b1;
    #1;
    chk("ign_rd_busy", ready, 0);
    @(negedge clk);
    en = 1'b0; tb_oe = 1'b0;
    #1;
    chk("ign_rd_ready", ready, 1);
    pop_chk("ign_rd_data");
    @(negedge clk);
    #1;
    chk("ign_rd_idle", ready, 0);

    @(negedge clk);
    en = 1'b1; rw = 1'b1; sel = 2'd3; tb_data = 8'h77; tb_oe = 1'b1;
    @(negedge clk);
    sel = 2'd0; tb_data = 8'hEE;
    #1;
    chk("ign_wr_ready", ready, 1);
    @(negedge clk);
    en = 1'b0; tb_oe = 1'b0;
    #1;
    chk("ign_wr_idle", ready, 0);
    do_read(2'd1, 8'h22, 1'b0);
    do_read(2'd0, 8'h11, 1'b0);
    do_read(2'd3, 8'h77, 1'b0);

    @(negedge clk);
    en = 1'b1; rw = 1'b0; sel = 2'd3;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_ready_before", ready, 1);
    chk("mid_rst_data_before", bus, 8'h77);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_hiz", bus, HIZ);
    @(negedge clk);
    rst_n = 1'b1;
    do_write(2'd1, 8'h3C);
    do_read(2'd1, 8'h3C, 1'b0);
    do_read(2'd3, 8'h00, 1'b0);

`ifdef MEMORY_PARITY_EN
    do_write(2'd1, 8'h07);
    dut.u_cells.mem[1][8] = 1'b0;
    do_read(2'd1, 8'h07, 1'b1);
    do_write(2'd2, 8'h5A);
    do_read(2'd2, 8'h5A, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
